// File: rtl/pwr_pkg.sv
// pwr_pkg: shared state encoding and width helper for the power/mode controller
package pwr_pkg;

    typedef enum logic [1:0] {OFF, STANDBY, ACTIVE, LOCKOUT} pwr_state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop sync, stability filter and press/release pulses for the power button
module button_debounce
    import pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = clog2_min1(DEBOUNCE_CYC + 1);

    logic           s1;
    logic           s2;
    logic [1:0]     sv;
    logic           raw;
    logic           armed;
    logic [CW-1:0]  cnt;

    // synchronise the raw button and track when the sync pipeline holds real samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            sv <= '0;
        end else begin
            s1 <= button;
            s2 <= s1;
            sv <= {sv[0], 1'b1};
        end
    end

    // accept a new level after it has been stable long enough; edges only count once a low was seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw   <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (s2 == raw)
                cnt <= '0;
            else if (cnt >= CW'(DEBOUNCE_CYC - 1)) begin
                raw   <= s2;
                cnt   <= '0;
                press <= s2 & armed;
                rel   <= ~s2 & armed;
            end else
                cnt <= cnt + 1'b1;
            if (sv[1] && !s2 && !raw)
                armed <= 1'b1;
        end
    end

    assign level = raw & armed;

endmodule

// File: rtl/power_mode_ctrl_param.sv
// power_mode_ctrl_param: button-driven OFF/STANDBY/ACTIVE/LOCKOUT controller with mode select and idle timeout
module power_mode_ctrl_param
    import pwr_pkg::*;
#(
    parameter int N_MODES      = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 300_000_000,
    parameter int IDLE_CYC     = 0,
    localparam int MODE_W      = clog2_min1(N_MODES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              power_button,
    input  logic [MODE_W-1:0] mode_select,
    input  logic              activity,
    output logic              power_state,
    output logic              mode_valid,
    output logic [MODE_W-1:0] current_mode,
    output logic              mode_error,
    output logic              long_evt
);

    localparam int HW = clog2_min1(LONG_CYC + 1);
    localparam int IW = clog2_min1(IDLE_CYC + 1);

    pwr_state_t    state;
    logic          lvl;
    logic          press;
    logic          rel;
    logic          consumed;
    logic [HW-1:0] hold;
    logic [IW-1:0] idle;
    logic          short_p;
    logic          long_ok;
    logic          idle_run;
    logic          idle_hit;
    logic          mode_ok;

    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk    (clk),
        .reset  (reset),
        .button (power_button),
        .level  (lvl),
        .press  (press),
        .rel    (rel)
    );

    assign short_p  = rel && !consumed && hold != HW'(LONG_CYC);
    assign long_ok  = long_evt && !consumed;
    assign idle_run = (IDLE_CYC != 0) && (state == STANDBY || state == ACTIVE) && !lvl && !activity && !press;
    assign idle_hit = idle_run && idle >= IW'(IDLE_CYC - 1);
    assign mode_ok  = {1'b0, mode_select} < (MODE_W + 1)'(N_MODES);

    // hold-time counter and the single long-press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            long_evt <= 1'b0;
        end else begin
            long_evt <= lvl && !press && hold == HW'(LONG_CYC - 1);
            hold     <= press ? '0 : (lvl && hold != HW'(LONG_CYC)) ? hold + 1'b1 : hold;
        end
    end

    // mode FSM with idle timer and registered outputs; button events take priority over expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= OFF;
            consumed     <= 1'b0;
            idle         <= '0;
            power_state  <= 1'b0;
            mode_valid   <= 1'b0;
            current_mode <= '0;
            mode_error   <= 1'b0;
        end else begin
            mode_error <= 1'b0;
            if (rel)
                consumed <= 1'b0;
            idle <= idle_run ? idle + IW'(idle != IW'(IDLE_CYC)) : '0;
            unique case (state)
                OFF: if (press) begin
                    state       <= STANDBY;
                    power_state <= 1'b1;
                    consumed    <= 1'b1;
                    idle        <= '0;
                end
                STANDBY: if (short_p) begin
                    if (mode_ok) begin
                        state        <= ACTIVE;
                        mode_valid   <= 1'b1;
                        current_mode <= mode_select;
                        idle         <= '0;
                    end else
                        mode_error <= 1'b1;
                end else if (long_ok) begin
                    state       <= LOCKOUT;
                    power_state <= 1'b0;
                    idle        <= '0;
                end else if (idle_hit) begin
                    state       <= OFF;
                    power_state <= 1'b0;
                    idle        <= '0;
                end
                ACTIVE: if (short_p || idle_hit) begin
                    state        <= STANDBY;
                    mode_valid   <= 1'b0;
                    current_mode <= '0;
                    idle         <= '0;
                end else if (long_ok) begin
                    state        <= LOCKOUT;
                    power_state  <= 1'b0;
                    mode_valid   <= 1'b0;
                    current_mode <= '0;
                    idle         <= '0;
                end
                LOCKOUT: if (rel)
                    state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_power_mode_ctrl_param.sv
// tb_power_mode_ctrl_param: directed checks of the power/mode controller
module tb_power_mode_ctrl_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       power_button = 1'b0;
    logic [1:0] mode_select = '0;
    logic       activity = 1'b0;
    logic       power_state;
    logic       mode_valid;
    logic [1:0] current_mode;
    logic       mode_error;
    logic       long_evt;

    int n_chk = 0;
    int n_pass = 0;
    int err_cnt = 0;
    int long_cnt = 0;
    int base;

    power_mode_ctrl_param #(
        .N_MODES(3), .DEBOUNCE_CYC(4), .LONG_CYC(20), .IDLE_CYC(50)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .power_button (power_button),
        .mode_select  (mode_select),
        .activity     (activity),
        .power_state  (power_state),
        .mode_valid   (mode_valid),
        .current_mode (current_mode),
        .mode_error   (mode_error),
        .long_evt     (long_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mode_error) err_cnt++;
        if (long_evt) long_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int n);
        power_button = 1'b1;
        cyc(n);
        power_button = 1'b0;
        cyc(8);
    endtask

    task automatic poke;
        activity = 1'b1;
        cyc(1);
        activity = 1'b0;
    endtask

    function automatic logic [31:0] outs;
        return {26'd0, power_state, mode_valid, current_mode, mode_error, long_evt};
    endfunction

    initial begin
        // 1: reset, glitch rejection, power-up press
        cyc(3);
        check("reset_outs", outs(), 32'd0);
        reset = 1'b1;
        cyc(5);
        power_button = 1'b1;
        cyc(2);
        power_button = 1'b0;
        cyc(10);
        check("glitch_ps", power_state, 1'b0);
        push(8);
        check("standby_ps", power_state, 1'b1);
        check("standby_mv", mode_valid, 1'b0);
        // 2: out-of-range mode then a valid mode
        base = err_cnt;
        mode_select = 2'd3;
        push(8);
        check("err_pulses", err_cnt - base, 1);
        check("err_ps", power_state, 1'b1);
        check("err_mv", mode_valid, 1'b0);
        mode_select = 2'd2;
        push(8);
        check("active_mv", mode_valid, 1'b1);
        check("active_mode", current_mode, 2'd2);
        mode_select = 2'd1;
        cyc(3);
        check("mode_hold", current_mode, 2'd2);
        // 3: long press to LOCKOUT, release goes to OFF
        base = long_cnt;
        power_button = 1'b1;
        cyc(30);
        check("long_pulses", long_cnt - base, 1);
        check("lock_ps", power_state, 1'b0);
        check("lock_mv", mode_valid, 1'b0);
        check("lock_mode", current_mode, 2'd0);
        power_button = 1'b0;
        cyc(10);
        check("off_ps", power_state, 1'b0);
        cyc(20);
        check("off_ps_stay", power_state, 1'b0);
        push(8);
        check("off_repower", power_state, 1'b1);
        push(8);
        check("active2_mv", mode_valid, 1'b1);
        check("active2_mode", current_mode, 2'd1);
        // 4: idle timeout with an activity restart
        poke();
        cyc(48);
        poke();
        check("idle_restart", mode_valid, 1'b1);
        cyc(49);
        check("idle_49_active", mode_valid, 1'b1);
        cyc(1);
        check("idle_to_standby_mv", mode_valid, 1'b0);
        check("idle_to_standby_ps", power_state, 1'b1);
        cyc(49);
        check("idle_49_standby", power_state, 1'b1);
        cyc(1);
        check("idle_to_off", power_state, 1'b0);
        // 5: reset mid-hold, held button after reset is ignored
        base = long_cnt;
        power_button = 1'b1;
        cyc(16);
        check("midhold_ps", power_state, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_outs", outs(), 32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(40);
        check("held_no_power", power_state, 1'b0);
        check("held_no_long", long_cnt - base, 0);
        power_button = 1'b0;
        cyc(10);
        push(8);
        check("after_reset_press", power_state, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
